pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
// Hazard/sequencing controller for the 5-stage RISC-V pipeline. Drives stall/flush per stage register
// (F, D, E, M, W) and EX-stage forwarding selects. Owns the data-memory access FSM: holds the whole
// pipeline while a load/store in M waits on dmem_ready, with a wait-timeout and a sticky error flag.
// PARAMETERS
// WAIT_MAX  15  max M_WAIT cycles before timeout release (1..255)
// CNT_W     8   width of wait-cycle counter; must hold WAIT_MAX
// PERF_W    32  width of performance counters (PIPE_PERF_EN only)
// PORTS
// clk          in   1   clock, all state on rising edge
// reset        in   1   asynchronous, active-low (0 = reset)
// Rs1D,Rs2D    in   5   source regs in Decode
// Rs1E,Rs2E    in   5   source regs in Execute
// RdE,RdM,RdW  in   5   dest regs in E/M/W
// ResultSrcE   in   2   01 = load in E
// ResultSrcM   in   2   01 = load in M
// MemWriteM    in   1   store in M
// RegWriteM,W  in   1   RegWriteM, RegWriteW: writeback enables in M/W
// PCSrcE       in   1   taken branch/jump resolved in E
// dmem_ready   in   1   data memory completes access this cycle
// dmem_req     out  1   data memory request
// StallF,StallD,StallE,StallM  out 1  hold stage register
// FlushD,FlushE,FlushW         out 1  clear stage register to bubble
// ForwardAE,ForwardBE          out 2  00 regfile, 01 from W, 10 from M
// mem_err      out  1   sticky: access timed out
// BEHAVIOUR
// - Reset: state=M_IDLE, wait_cnt=0, mem_err=0; all stall/flush=0, dmem_req=0.
// - memop = MemWriteM | (ResultSrcM==01). dmem_req = memop (combinational, any state).
// - FSM M_IDLE: memop & !dmem_ready -> M_WAIT, wait_cnt<=1; memop & dmem_ready -> stay (0-wait access).
// - M_WAIT: dmem_ready -> M_IDLE, wait_cnt<=0; else wait_cnt==WAIT_MAX -> M_IDLE, mem_err<=1; else wait_cnt++.
// - memStall = memop & !dmem_ready & !(state==M_WAIT & wait_cnt==WAIT_MAX). Combinational, no added latency.
// - memStall=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0 (all other hazards masked).
// - lwStall = (ResultSrcE==01) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D). If !memStall: StallF=StallD=1, FlushE=1.
// - If !memStall & PCSrcE: FlushD=1, FlushE=1 (branch wins over lwStall for D: FlushD set, StallD still 1 harmless).
// - Branch during memStall: E is held, PCSrcE remains high, flush applied on first non-stall cycle.
// - Forwarding (per operand, Rs1E->ForwardAE, Rs2E->ForwardBE): 10 if RegWriteM & RdM!=0 & RdM==RsXE;
//   else 01 if RegWriteW & RdW!=0 & RdW==RsXE; else 00. M has priority over W. x0 never forwarded.
// - Forwarding not gated by stalls. mem_err clears only on reset.
// - Reset mid-wait: immediate return to M_IDLE, outputs to reset values; no pending state retained.
// CONFIGURATION
// PIPE_PERF_EN defined: adds outputs perf_stall_cyc[PERF_W] (+1 each cycle memStall|lwStall) and
//   perf_flush_cnt[PERF_W] (+1 each cycle FlushE=1); both saturate at all-ones, reset to 0.
// PIPE_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
// 1 reset=0 with dmem_ready=0, MemWriteM=1 -> all outputs 0, state M_IDLE; release -> StallM=1 same cycle.
// 2 load in M, dmem_ready low 3 cycles then high -> stalls high 3 cycles, FlushW high 3 cycles, 4th cycle 0.
// 3 ResultSrcE=01, RdE=5, Rs2D=5 -> StallF=StallD=FlushE=1 one cycle; RdE=0 case -> no stall.
// 4 RegWriteM=1,RdM=7,RegWriteW=1,RdW=7,Rs1E=7 -> ForwardAE=10; RegWriteM=0 -> 01; Rs1E=0,RdM=0 -> 00.
// 5 dmem_ready held 0, WAIT_MAX=15 -> stall 15 cycles, release on 16th, mem_err=1 stays until reset.
// 6 PCSrcE=1 during 2-cycle memStall -> FlushD/E=0 while stalled, FlushD=FlushE=1 on release cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the 5-stage pipeline datapath and its hazard controller.
// The pipeline side uses modport master, the controller uses modport slave.
// Optional performance counter outputs are present only when PIPE_PERF_EN is defined.
interface pipe_hazard_ctrl_if
`ifdef PIPE_PERF_EN
  #(parameter int unsigned PERF_W = 32)
`endif
  ;
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] Rs1E;
  logic [4:0] Rs2E;
  logic [4:0] RdE;
  logic [4:0] RdM;
  logic [4:0] RdW;
  logic [1:0] ResultSrcE;
  logic [1:0] ResultSrcM;
  logic       MemWriteM;
  logic       RegWriteM;
  logic       RegWriteW;
  logic       PCSrcE;
  logic       dmem_ready;
  logic       dmem_req;
  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       StallM;
  logic       FlushD;
  logic       FlushE;
  logic       FlushW;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic       mem_err;
`ifdef PIPE_PERF_EN
  logic [PERF_W-1:0] perf_stall_cyc;
  logic [PERF_W-1:0] perf_flush_cnt;
`endif

  modport master (
`ifdef PIPE_PERF_EN
    input  perf_stall_cyc, perf_flush_cnt,
`endif
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output ResultSrcE, ResultSrcM, MemWriteM, RegWriteM, RegWriteW,
    output PCSrcE, dmem_ready,
    input  dmem_req, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, ForwardAE, ForwardBE, mem_err
  );

  modport slave (
`ifdef PIPE_PERF_EN
    output perf_stall_cyc, perf_flush_cnt,
`endif
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  ResultSrcE, ResultSrcM, MemWriteM, RegWriteM, RegWriteW,
    input  PCSrcE, dmem_ready,
    output dmem_req, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, ForwardAE, ForwardBE, mem_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RISC-V pipeline.
// Generates per-stage stall/flush, EX-stage forwarding selects, and runs the
// data-memory wait FSM (whole-pipeline hold, wait timeout, sticky mem_err).
// Optional feature macro: PIPE_PERF_EN adds saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 8
`ifdef PIPE_PERF_EN
  , parameter int unsigned PERF_W = 32
`endif
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  hz
);

  typedef enum logic [0:0] {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mstate_t;

  mstate_t          state;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_err_q;

  logic       memop;
  logic       at_limit;
  logic       mem_stall;
  logic       lw_stall;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;
  logic       req;
  logic [1:0] fwd_a, fwd_b;

  assign memop    = hz.MemWriteM | (hz.ResultSrcM == 2'b01);
  // The final permitted wait cycle releases the pipeline even if memory never answers.
  assign at_limit = (state == M_WAIT) && (wait_cnt == CNT_W'(WAIT_MAX));
  assign mem_stall = memop & ~hz.dmem_ready & ~at_limit;
  assign lw_stall  = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  // Stall/flush/forward decode; everything is forced to zero while reset is held.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    req     = 1'b0;
    fwd_a   = 2'b00;
    fwd_b   = 2'b00;
    if (reset) begin
      req = memop;
      if (mem_stall) begin
        // Memory hold freezes F..M and bubbles W; branch/load-use effects wait
        // until the first non-stalled cycle (PCSrcE stays valid because E is held).
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else begin
        if (lw_stall) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
        if (hz.PCSrcE) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end
      end

      if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs1E))
        fwd_a = 2'b10;
      else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs1E))
        fwd_a = 2'b01;

      if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs2E))
        fwd_b = 2'b10;
      else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs2E))
        fwd_b = 2'b01;
    end
  end

  // Data-memory access FSM: wait counting, timeout release, sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= M_IDLE;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state)
        M_IDLE: begin
          if (memop && !hz.dmem_ready) begin
            state    <= M_WAIT;
            wait_cnt <= CNT_W'(1);
          end
        end
        M_WAIT: begin
          if (hz.dmem_ready) begin
            state    <= M_IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_W'(WAIT_MAX)) begin
            state     <= M_IDLE;
            wait_cnt  <= '0;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= M_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  assign hz.dmem_req  = req;
  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.StallM    = stall_m;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.FlushW    = flush_w;
  assign hz.ForwardAE = fwd_a;
  assign hz.ForwardBE = fwd_b;
  assign hz.mem_err   = mem_err_q;

`ifdef PIPE_PERF_EN
  logic [PERF_W-1:0] perf_stall_q;
  logic [PERF_W-1:0] perf_flush_q;

  // Saturating counters of stalled cycles and E-stage flushes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if ((mem_stall || lw_stall) && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + PERF_W'(1);
      if (flush_e && (perf_flush_q != '1))
        perf_flush_q <= perf_flush_q + PERF_W'(1);
    end
  end

  assign hz.perf_stall_cyc = perf_stall_q;
  assign hz.perf_flush_cnt = perf_flush_q;
`endif

endmodule
